// File: rtl/wb_pkg.sv
// Shared definitions for the Wishbone RAM slave: FSM encoding, SEL constants,
// the latched request payload and a lane-mask helper.
package wb_pkg;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned ADR_W  = 32;
   localparam int unsigned SEL_W  = 4;
   localparam int unsigned CNT_W  = 4;

   localparam logic [SEL_W-1:0] SEL_BYTE = 4'b0001;
   localparam logic [SEL_W-1:0] SEL_HALF = 4'b0011;
   localparam logic [SEL_W-1:0] SEL_WORD = 4'b1111;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      ACK  = 2'd2
   } state_t;

   typedef struct packed {
      logic              we;
      logic [SEL_W-1:0]  sel;
      logic [ADR_W-1:0]  adr;
      logic [DATA_W-1:0] dat;
   } req_t;

   // Expand a 4-bit lane select into a 32-bit byte mask.
   function automatic logic [DATA_W-1:0] lane_mask(input logic [SEL_W-1:0] sel);
      return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
   endfunction

endpackage

// File: rtl/wb_ram_slave_if.sv
// Wishbone classic bus bundle between a master and the RAM slave.
//   CYC_I/STB_I/WE_I/ADR_I/SEL_I/DAT_I : master -> slave request
//   DAT_O/ACK_O/ERR_O                  : slave -> master response
interface wb_ram_slave_if;
   import wb_pkg::*;

   logic              CYC_I;
   logic              STB_I;
   logic              WE_I;
   logic [ADR_W-1:0]  ADR_I;
   logic [SEL_W-1:0]  SEL_I;
   logic [DATA_W-1:0] DAT_I;
   logic [DATA_W-1:0] DAT_O;
   logic              ACK_O;
   logic              ERR_O;

   modport master (
      output CYC_I, STB_I, WE_I, ADR_I, SEL_I, DAT_I,
      input  DAT_O, ACK_O, ERR_O
   );

   modport slave (
      input  CYC_I, STB_I, WE_I, ADR_I, SEL_I, DAT_I,
      output DAT_O, ACK_O, ERR_O
   );

endinterface

// File: rtl/wb_ram_array.sv
// Single-port synchronous RAM, 32-bit words, per-byte-lane write enables.
//   clk   : clock
//   we    : byte-lane write enables
//   re    : read enable, rdata updates on the same edge
//   addr  : word index
//   wdata : write data, lane aligned
//   rdata : registered read word (contents are never reset)
module wb_ram_array #(
   parameter int unsigned AW = 12
) (
   input  logic          clk,
   input  logic [3:0]    we,
   input  logic          re,
   input  logic [AW-1:0] addr,
   input  logic [31:0]   wdata,
   output logic [31:0]   rdata
);

   localparam int unsigned DEPTH = 1 << AW;

   logic [31:0] mem [DEPTH];

   // Byte-lane writes and registered read.
   always_ff @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
      if (re) rdata <= mem[addr];
   end

endmodule

// File: rtl/wb_ram_slave.sv
// Wishbone classic RAM slave with configurable wait states.
//   CLK_I : clock, rising edge
//   RST_I : asynchronous active-low reset
//   bus   : wb_ram_slave_if.slave (request in, DAT_O/ACK_O/ERR_O out)
// Optional macro WB_RAM_ERR_EN: misaligned or out-of-range accesses answer
// with ERR_O instead of ACK_O and have no side effect. Without it ERR_O is 0,
// misaligned lanes are truncated and the address wraps modulo depth.
module wb_ram_slave
   import wb_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH  = 12,
   parameter int unsigned WAIT_STATES = 1
) (
   input  logic           CLK_I,
   input  logic           RST_I,
   wb_ram_slave_if.slave  bus
);

   state_t                state, state_next;
   logic [CNT_W-1:0]      cnt, cnt_next;
   req_t                  req_q, req_c;
   logic                  fin_c;
   logic                  bad_c;
   logic [1:0]            off_c;
   logic [ADDR_WIDTH-1:0] idx_c;
   logic [3:0]            be_c;
   logic [31:0]           wdata_c;
   logic [3:0]            ram_we_c;
   logic                  ram_re_c;
   logic [31:0]           ram_q;
   logic [3:0]            rd_sel;
   logic [1:0]            rd_off;
   logic                  ack;

   // In IDLE the request comes straight off the bus so a zero-wait access can finish on the sampling edge.
   always_comb begin
      req_c = req_q;
      if (state == IDLE) begin
         req_c.we  = bus.WE_I;
         req_c.sel = bus.SEL_I;
         req_c.adr = bus.ADR_I;
         req_c.dat = bus.DAT_I;
      end
   end

   assign off_c   = req_c.adr[1:0];
   assign idx_c   = req_c.adr[ADDR_WIDTH+1:2];
   assign be_c    = 4'({4'b0000, req_c.sel} << off_c);
   assign wdata_c = req_c.dat << {off_c, 3'b000};

`ifdef WB_RAM_ERR_EN
   logic mis_c;
   logic oob_c;
   logic err;

   assign mis_c = ((req_c.sel == SEL_HALF) && (off_c == 2'd3)) ||
                  ((req_c.sel == SEL_WORD) && (off_c != 2'd0));
   assign oob_c = (33'(req_c.adr[31:2]) >> ADDR_WIDTH) != 33'd0;
   assign bad_c = mis_c || oob_c;

   // Error response takes the slot the acknowledge would have had.
   always_ff @(posedge CLK_I or negedge RST_I) begin
      if (!RST_I) err <= 1'b0;
      else        err <= fin_c && bad_c;
   end
   assign bus.ERR_O = err;
`else
   logic unused_adr;

   assign bad_c      = 1'b0;
   assign unused_adr = ^req_c.adr[31:ADDR_WIDTH+2];
   assign bus.ERR_O  = 1'b0;
`endif

   // Next state: IDLE -> WAIT (WAIT_STATES cycles) -> ACK -> IDLE; CYC_I low in WAIT aborts.
   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      fin_c      = 1'b0;
      unique case (state)
         IDLE: begin
            if (bus.CYC_I && bus.STB_I) begin
               cnt_next = '0;
               if (WAIT_STATES == 0) begin
                  state_next = ACK;
                  fin_c      = 1'b1;
               end else begin
                  state_next = WAIT;
               end
            end
         end
         WAIT: begin
            if (!bus.CYC_I) begin
               state_next = IDLE;
               cnt_next   = '0;
            end else if (cnt == CNT_W'(WAIT_STATES - 1)) begin
               state_next = ACK;
               cnt_next   = '0;
               fin_c      = 1'b1;
            end else begin
               cnt_next = cnt + 1'b1;
            end
         end
         ACK:     state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Commit only on the edge entering ACK, and never while reset is held.
   assign ram_we_c = (fin_c && !bad_c && req_c.we && RST_I) ? be_c : 4'b0000;
   assign ram_re_c = fin_c && !bad_c && !req_c.we && RST_I;

   // State, latched request and read-format registers.
   always_ff @(posedge CLK_I or negedge RST_I) begin
      if (!RST_I) begin
         state  <= IDLE;
         cnt    <= '0;
         req_q  <= '0;
         ack    <= 1'b0;
         rd_sel <= '0;
         rd_off <= '0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
         ack   <= fin_c && !bad_c;
         if (state == IDLE && bus.CYC_I && bus.STB_I) req_q <= req_c;
         if (ram_re_c) begin
            rd_sel <= req_c.sel;
            rd_off <= off_c;
         end
      end
   end

   wb_ram_array #(.AW(ADDR_WIDTH)) u_array (
      .clk   (CLK_I),
      .we    (ram_we_c),
      .re    (ram_re_c),
      .addr  (idx_c),
      .wdata (wdata_c),
      .rdata (ram_q)
   );

   // rd_sel resets to zero, which forces DAT_O to zero until the first read.
   assign bus.DAT_O = (ram_q >> {rd_off, 3'b000}) & lane_mask(rd_sel);
   assign bus.ACK_O = ack;

endmodule

// File: tb/tb_wb_ram_slave.sv
// Self-checking bench for wb_ram_slave: directed vector table, hand-written
// abort/reset/back-to-back sequences and random traffic against a byte-lane
// reference model.
module tb_wb_ram_slave;
   import wb_pkg::*;

   localparam int unsigned AW    = 12;
   localparam int unsigned WS    = 1;
   localparam int unsigned DEPTH = 1 << AW;
`ifdef WB_RAM_ERR_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   logic CLK_I = 1'b0;
   logic RST_I = 1'b0;

   wb_ram_slave_if bus();

   wb_ram_slave #(.ADDR_WIDTH(AW), .WAIT_STATES(WS)) dut (
      .CLK_I (CLK_I),
      .RST_I (RST_I),
      .bus   (bus)
   );

   always #5 CLK_I = ~CLK_I;

   int total = 0;
   int bad   = 0;

   logic [31:0] mdl [DEPTH];
   logic [31:0] exp_dato = 32'h0;

   typedef struct {
      bit          we;
      logic [31:0] adr;
      logic [3:0]  sel;
      logic [31:0] dat;
      logic [31:0] exp;
   } vec_t;

   vec_t tv [8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   // Reference: applies the access to the model memory, returns whether it errors.
   task automatic mdl_xfer(input bit we, input logic [31:0] adr, input logic [3:0] sel,
                           input logic [31:0] dat, output bit exp_err);
      int unsigned o   = 32'(adr[1:0]);
      int unsigned idx = (adr >> 2) % DEPTH;
      bit mis = (sel == 4'b0011 && o == 3) || (sel == 4'b1111 && o != 0);
      bit oob = (adr >> 2) >= DEPTH;
      logic [31:0] rd = 32'h0;
      exp_err = ERR_EN && (mis || oob);
      if (!exp_err) begin
         if (we) begin
            // Byte k of DAT_I lands in lane k+o when that lane exists.
            for (int k = 0; k < 4; k++)
               if (sel[k] && (k + o) < 4) mdl[idx][8*(k+o) +: 8] = dat[8*k +: 8];
         end else begin
            for (int k = 0; k < 4; k++)
               if (sel[k] && (k + o) < 4) rd[8*k +: 8] = mdl[idx][8*(k+o) +: 8];
            exp_dato = rd;
         end
      end
   endtask

   // Drives one request, waits for ACK/ERR (bounded), then leaves one idle cycle.
   task automatic bus_xfer(input bit we, input logic [31:0] adr, input logic [3:0] sel,
                           input logic [31:0] dat, output bit ack_seen, output bit err_seen,
                           output int lat);
      bus.CYC_I = 1'b1; bus.STB_I = 1'b1; bus.WE_I = we;
      bus.ADR_I = adr;  bus.SEL_I = sel;  bus.DAT_I = dat;
      ack_seen = 1'b0; err_seen = 1'b0; lat = 0;
      for (int c = 1; c <= 20; c++) begin
         @(posedge CLK_I); #1;
         if (bus.ACK_O || bus.ERR_O) begin
            ack_seen = bus.ACK_O;
            err_seen = bus.ERR_O;
            lat      = c;
            break;
         end
      end
      bus.CYC_I = 1'b0; bus.STB_I = 1'b0;
      @(posedge CLK_I); #1;
   endtask

   task automatic run_check(input string name, input bit we, input logic [31:0] adr,
                            input logic [3:0] sel, input logic [31:0] dat);
      bit e_err, a_ack, a_err;
      int lat;
      logic [31:0] dato;
      mdl_xfer(we, adr, sel, dat, e_err);
      bus_xfer(we, adr, sel, dat, a_ack, a_err, lat);
      dato = bus.DAT_O;
      chk({name, " ack"}, 32'(a_ack), 32'(!e_err));
      chk({name, " err"}, 32'(a_err), 32'(e_err));
      chk({name, " latency"}, 32'(lat), 32'(WS + 1));
      if (!we) chk({name, " dat"}, dato, exp_dato);
   endtask

   initial begin
      int acks;
      bit e_err;
      logic [31:0] adr;
      logic [3:0]  sel;

      tv[0] = '{1'b1, 32'h10, 4'b1111, 32'hDEADBEEF, 32'h0};
      tv[1] = '{1'b0, 32'h10, 4'b1111, 32'h0,        32'hDEADBEEF};
      tv[2] = '{1'b1, 32'h13, 4'b0001, 32'h0000005A, 32'h0};
      tv[3] = '{1'b0, 32'h10, 4'b1111, 32'h0,        32'h5AADBEEF};
      tv[4] = '{1'b0, 32'h13, 4'b0001, 32'h0,        32'h0000005A};
      tv[5] = '{1'b0, 32'h12, 4'b0011, 32'h0,        32'h00005AAD};
      tv[6] = '{1'b1, 32'h20, 4'b1111, 32'hCAFEF00D, 32'h0};
      tv[7] = '{1'b0, 32'h20, 4'b1111, 32'h0,        32'hCAFEF00D};

      bus.CYC_I = 1'b0; bus.STB_I = 1'b0; bus.WE_I = 1'b0;
      bus.ADR_I = '0;   bus.SEL_I = '0;   bus.DAT_I = '0;

      repeat (3) @(posedge CLK_I);
      #1;
      chk("reset ack", 32'(bus.ACK_O), 32'h0);
      chk("reset err", 32'(bus.ERR_O), 32'h0);
      chk("reset dat", bus.DAT_O, 32'h0);
      RST_I = 1'b1;
      @(posedge CLK_I); #1;

      // Directed vectors
      for (int i = 0; i < 8; i++) begin
         run_check($sformatf("vec%0d", i), tv[i].we, tv[i].adr, tv[i].sel, tv[i].dat);
         if (!tv[i].we) chk($sformatf("vec%0d table", i), bus.DAT_O, tv[i].exp);
      end

      // Drop CYC_I during WAIT of a write: no ack, memory unchanged
      bus.CYC_I = 1'b1; bus.STB_I = 1'b1; bus.WE_I = 1'b1;
      bus.ADR_I = 32'h20; bus.SEL_I = 4'b1111; bus.DAT_I = 32'h11111111;
      @(posedge CLK_I); #1;
      bus.CYC_I = 1'b0; bus.STB_I = 1'b0;
      acks = 0;
      repeat (4) begin
         @(posedge CLK_I); #1;
         acks += int'(bus.ACK_O) + int'(bus.ERR_O);
      end
      chk("abort no ack", 32'(acks), 32'h0);
      run_check("abort readback", 1'b0, 32'h20, 4'b1111, 32'h0);
      chk("abort readback const", bus.DAT_O, 32'hCAFEF00D);

      // Misaligned word read
      run_check("misaligned word", 1'b0, 32'h22, 4'b1111, 32'h0);
      chk("misaligned word const", bus.DAT_O, ERR_EN ? 32'hCAFEF00D : 32'h0000CAFE);

      // Reset during WAIT of a write
      bus.CYC_I = 1'b1; bus.STB_I = 1'b1; bus.WE_I = 1'b1;
      bus.ADR_I = 32'h10; bus.SEL_I = 4'b1111; bus.DAT_I = 32'h77777777;
      @(posedge CLK_I); #1;
      RST_I = 1'b0;
      #1;
      chk("midreset ack", 32'(bus.ACK_O), 32'h0);
      chk("midreset err", 32'(bus.ERR_O), 32'h0);
      chk("midreset dat", bus.DAT_O, 32'h0);
      exp_dato = 32'h0;
      bus.CYC_I = 1'b0; bus.STB_I = 1'b0;
      @(posedge CLK_I); #1;
      RST_I = 1'b1;
      acks = 0;
      repeat (3) begin
         @(posedge CLK_I); #1;
         acks += int'(bus.ACK_O) + int'(bus.ERR_O);
      end
      chk("postreset no ack", 32'(acks), 32'h0);
      run_check("postreset read", 1'b0, 32'h10, 4'b1111, 32'h0);
      chk("postreset read const", bus.DAT_O, 32'h5AADBEEF);

      // STB_I held after ACK is a new request: ack every WS+2 cycles
      bus.CYC_I = 1'b1; bus.STB_I = 1'b1; bus.WE_I = 1'b0;
      bus.ADR_I = 32'h10; bus.SEL_I = 4'b1111;
      for (int k = 1; k <= 6; k++) begin
         @(posedge CLK_I); #1;
         chk($sformatf("b2b ack c%0d", k), 32'(bus.ACK_O), 32'((k % (WS + 2)) == (WS + 1)));
      end
      bus.CYC_I = 1'b0; bus.STB_I = 1'b0;
      @(posedge CLK_I); #1;

      // STB_I without CYC_I is ignored
      bus.STB_I = 1'b1; bus.WE_I = 1'b1; bus.DAT_I = 32'h0BADF00D;
      acks = 0;
      repeat (4) begin
         @(posedge CLK_I); #1;
         acks += int'(bus.ACK_O) + int'(bus.ERR_O);
      end
      bus.STB_I = 1'b0;
      chk("no cyc ignored", 32'(acks), 32'h0);
      run_check("no cyc readback", 1'b0, 32'h10, 4'b1111, 32'h0);

      // Random traffic over the first 64 words, after filling them
      for (int w = 0; w < 64; w++)
         run_check($sformatf("fill%0d", w), 1'b1, 32'(w * 4), 4'b1111, $urandom);
      for (int n = 0; n < 250; n++) begin
         adr = 32'($urandom_range(0, 255));
         if ($urandom_range(0, 7) == 0) adr = adr | 32'h0001_0000;
         case ($urandom_range(0, 2))
            0:       sel = SEL_BYTE;
            1:       sel = SEL_HALF;
            default: sel = SEL_WORD;
         endcase
         run_check($sformatf("rnd%0d", n), bit'($urandom_range(0, 1)), adr, sel, $urandom);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: no finish after 500000 time units");
      $fatal(1);
   end

endmodule

// File: doc/wb_ram_slave.md
WB_RAM_SLAVE -- requirements
Module: wb_ram_slave

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 12, word-address width; depth is 2**ADDR_WIDTH 32-bit words.
REQ-002 SHALL have parameter WAIT_STATES, default 1, extra cycles inserted before acknowledge (0..15).
REQ-003 SHALL have one clock; reset is asynchronous and active-low.
REQ-004 CLK_I  input  1  clock, all logic on rising edge.
REQ-005 RST_I  input  1  asynchronous active-low reset.
REQ-006 CYC_I  input  1  bus cycle in progress.
REQ-007 STB_I  input  1  strobe, request valid.
REQ-008 WE_I  input  1  1 = write, 0 = read.
REQ-009 ADR_I  input  32  byte address.
REQ-010 SEL_I  input  4  lane-relative byte select: 0001 byte, 0011 half, 1111 word.
REQ-011 DAT_I  input  32  write data, low-justified.
REQ-012 DAT_O  output  32  read data, low-justified.
REQ-013 ACK_O  output  1  transfer complete.
REQ-014 ERR_O  output  1  transfer error (see Configuration).

Function
REQ-015 SHALL implement FSM states IDLE, WAIT, ACK.
REQ-016 In IDLE, CYC_I&STB_I SHALL latch ADR_I, SEL_I, WE_I, DAT_I and go to WAIT, or to ACK if WAIT_STATES=0.
REQ-017 WAIT SHALL count WAIT_STATES cycles, then go to ACK; latency request-sampled to ACK_O high = WAIT_STATES+1 cycles.
REQ-018 ACK_O SHALL be high exactly one cycle, in state ACK; next state always IDLE.
REQ-019 Word index SHALL be ADR_I[ADDR_WIDTH+1:2]; offset o = ADR_I[1:0].
REQ-020 Effective byte enables SHALL be SEL_I << o; write data SHALL be DAT_I << 8*o; enables shifted past lane 3 are dropped.
REQ-021 Read data SHALL be (word >> 8*o), masked to SEL_I lanes; upper bits zero; no sign extension.
REQ-022 Memory write and read capture SHALL occur on the edge entering ACK; DAT_O SHALL hold its value until the next ACK.
REQ-023 CYC_I low while in WAIT SHALL abort: return to IDLE, no write, no ACK_O.
REQ-024 STB_I still high in the IDLE cycle after ACK SHALL be treated as a new request.
REQ-025 Requests with CYC_I low SHALL be ignored.

Reset
REQ-026 RST_I low SHALL asynchronously force state IDLE, wait counter 0, ACK_O=0, ERR_O=0, DAT_O=0.
REQ-027 Reset mid-transfer SHALL cancel it; any write not yet committed SHALL NOT occur.
REQ-028 Memory contents SHALL NOT be reset.

Configuration
REQ-029 Macro WB_RAM_ERR_EN defined: misaligned access (half with o=3, word with o!=0) or word index >= depth SHALL assert ERR_O instead of ACK_O, same timing, no write, DAT_O unchanged.
REQ-030 WB_RAM_ERR_EN undefined: ERR_O tied 0; misaligned lanes truncated per REQ-020; address bits above ADDR_WIDTH+1 ignored, wrapping modulo depth.

Structure
REQ-031 Shared package wb_pkg SHALL hold FSM state encoding and SEL constants SEL_BYTE=0001, SEL_HALF=0011, SEL_WORD=1111.
REQ-032 Storage SHALL be sub-module wb_ram_array: single-port synchronous RAM, 4 byte-lane write enables, 32-bit read.

Verification
REQ-033 WAIT_STATES=1: write word 0xDEADBEEF @0x10, SEL=1111 -> ACK_O high 2 cycles after request; read @0x10 -> DAT_O=0xDEADBEEF.
REQ-034 Byte write 0x5A @0x13, SEL=0001 over 0xDEADBEEF -> word read @0x10 = 0x5AADBEEF; byte read @0x13 = 0x0000005A.
REQ-035 Half read @0x12 of 0x5AADBEEF, SEL=0011 -> DAT_O=0x00005AAD.
REQ-036 Drop CYC_I during WAIT on write 0x11111111 @0x20 -> no ACK_O; later read @0x20 returns prior contents.
REQ-037 WB_RAM_ERR_EN, word read @0x22 -> ERR_O one cycle, ACK_O stays 0; without macro, same access -> ACK_O, lanes truncated.
REQ-038 Assert RST_I low in WAIT of a write -> ACK_O=0 immediately, state IDLE, memory unchanged.
